// File: rtl/axis_tb_pkg.sv
// Shared types and helpers for the AXI4-Stream frame source and its checkers.
// pack_beat supports DATA_W up to MAX_DATA_W and index widths up to MAX_IDX_W.
package axis_tb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam int SOF_BIT    = 0;
  localparam int MAX_DATA_W = 256;
  localparam int MAX_IDX_W  = 64;

  // Beat payload: frame index in the upper half, beat index in the lower half.
  function automatic logic [MAX_DATA_W-1:0] pack_beat(
    input logic [MAX_IDX_W-1:0] f,
    input logic [MAX_IDX_W-1:0] b,
    input int unsigned          half_w
  );
    logic [MAX_DATA_W-1:0] mask;
    logic [MAX_DATA_W-1:0] f_w;
    logic [MAX_DATA_W-1:0] b_w;
    mask = (MAX_DATA_W'(1'b1) << half_w) - MAX_DATA_W'(1'b1);
    f_w  = MAX_DATA_W'(f) & mask;
    b_w  = MAX_DATA_W'(b) & mask;
    return (f_w << half_w) | b_w;
  endfunction

endpackage

// File: rtl/axis_beat_counter.sv
// Beat/frame index pair for the frame source. Exposes the post-edge indices so
// the owner can register the payload of the beat that will be presented next.
module axis_beat_counter #(
  parameter int LEN_W = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             clear,
  input  logic             advance,
  input  logic [LEN_W-1:0] beat_last,
  input  logic [LEN_W-1:0] frame_last,
  output logic [LEN_W-1:0] next_beat,
  output logic [LEN_W-1:0] next_frame,
  output logic             beat_wrap,
  output logic             frame_wrap
);

  logic [LEN_W-1:0] beat_r;
  logic [LEN_W-1:0] frame_r;
  logic [LEN_W-1:0] next_beat_s;
  logic [LEN_W-1:0] next_frame_s;
  logic             beat_wrap_s;
  logic             frame_wrap_s;

  // Wrap detection and next-index computation.
  always_comb begin
    beat_wrap_s  = advance && (beat_r == beat_last);
    frame_wrap_s = beat_wrap_s && (frame_r == frame_last);
    next_beat_s  = beat_r;
    next_frame_s = frame_r;
    if (clear) begin
      next_beat_s  = {LEN_W{1'b0}};
      next_frame_s = {LEN_W{1'b0}};
    end else if (beat_wrap_s) begin
      next_beat_s  = {LEN_W{1'b0}};
      next_frame_s = frame_r + LEN_W'(1'b1);
    end else if (advance) begin
      next_beat_s  = beat_r + LEN_W'(1'b1);
    end else begin
      next_beat_s  = beat_r;
      next_frame_s = frame_r;
    end
  end

  // Index registers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      beat_r  <= {LEN_W{1'b0}};
      frame_r <= {LEN_W{1'b0}};
    end else begin
      beat_r  <= next_beat_s;
      frame_r <= next_frame_s;
    end
  end

  assign next_beat  = next_beat_s;
  assign next_frame = next_frame_s;
  assign beat_wrap  = beat_wrap_s;
  assign frame_wrap = frame_wrap_s;

endmodule

// File: rtl/axis_frame_source.sv
// AXI4-Stream master emitting numbered test frames with SOF on tuser, a
// programmable tail tkeep, inter-frame gaps and full backpressure support.
module axis_frame_source
  import axis_tb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int KEEP_W = DATA_W / 8,
  parameter int USER_W = 1,
  parameter int LEN_W  = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic [LEN_W-1:0]  num_frames,
  input  logic [7:0]        gap_cycles,
  input  logic [KEEP_W-1:0] last_keep,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic [USER_W-1:0] m_axis_tuser,
  output logic              busy,
  output logic              done,
  output logic [31:0]       frames_sent
);

  state_t            state_r;
  logic [LEN_W-1:0]  len_m1_r;
  logic [LEN_W-1:0]  frames_m1_r;
  logic [7:0]        gap_r;
  logic [7:0]        gap_cnt_r;
  logic [KEEP_W-1:0] last_keep_r;
  logic              tvalid_r;
  logic [DATA_W-1:0] tdata_r;
  logic [KEEP_W-1:0] tkeep_r;
  logic              tlast_r;
  logic [USER_W-1:0] tuser_r;
  logic              busy_r;
  logic              done_r;
  logic [31:0]       frames_sent_r;

  logic              clear_s;
  logic              advance_s;
  logic [LEN_W-1:0]  next_beat_s;
  logic [LEN_W-1:0]  next_frame_s;
  logic              beat_wrap_s;
  logic              frame_wrap_s;
  logic [DATA_W-1:0] tdata_s;
  logic [KEEP_W-1:0] tkeep_s;
  logic              tlast_s;
  logic [USER_W-1:0] tuser_s;

  assign clear_s   = (state_r == IDLE) && start;
  assign advance_s = (state_r == SEND) && tvalid_r && m_axis_tready;

  axis_beat_counter #(
    .LEN_W (LEN_W)
  ) u_beat_counter (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .clear      (clear_s),
    .advance    (advance_s),
    .beat_last  (len_m1_r),
    .frame_last (frames_m1_r),
    .next_beat  (next_beat_s),
    .next_frame (next_frame_s),
    .beat_wrap  (beat_wrap_s),
    .frame_wrap (frame_wrap_s)
  );

  // Payload of the beat addressed by the post-edge indices.
  always_comb begin
    tdata_s          = DATA_W'(pack_beat(MAX_IDX_W'(next_frame_s), MAX_IDX_W'(next_beat_s), DATA_W / 2));
    tlast_s          = (next_beat_s == len_m1_r);
    tkeep_s          = tlast_s ? last_keep_r : {KEEP_W{1'b1}};
    tuser_s          = {USER_W{1'b0}};
    tuser_s[SOF_BIT] = (next_beat_s == {LEN_W{1'b0}});
  end

  // Frame sequencing FSM with registered stream and status outputs.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r       <= IDLE;
      len_m1_r      <= {LEN_W{1'b0}};
      frames_m1_r   <= {LEN_W{1'b0}};
      gap_r         <= 8'd0;
      gap_cnt_r     <= 8'd0;
      last_keep_r   <= {KEEP_W{1'b1}};
      tvalid_r      <= 1'b0;
      tdata_r       <= {DATA_W{1'b0}};
      tkeep_r       <= {KEEP_W{1'b0}};
      tlast_r       <= 1'b0;
      tuser_r       <= {USER_W{1'b0}};
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      frames_sent_r <= 32'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            len_m1_r    <= (frame_len == {LEN_W{1'b0}}) ? {LEN_W{1'b0}} : frame_len - LEN_W'(1'b1);
            frames_m1_r <= num_frames - LEN_W'(1'b1);
            gap_r       <= gap_cycles;
            last_keep_r <= (last_keep == {KEEP_W{1'b0}}) ? {KEEP_W{1'b1}} : last_keep;
            if (num_frames != {LEN_W{1'b0}}) begin
              state_r <= SEND;
              busy_r  <= 1'b1;
            end else begin
              state_r <= FIN;
              done_r  <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        SEND: begin
          // The first beat after start is loaded one cycle after config latches.
          if (!tvalid_r) begin
            tvalid_r <= 1'b1;
            tdata_r  <= tdata_s;
            tkeep_r  <= tkeep_s;
            tlast_r  <= tlast_s;
            tuser_r  <= tuser_s;
          end else if (m_axis_tready) begin
            if (beat_wrap_s) begin
              frames_sent_r <= frames_sent_r + 32'd1;
            end else begin
              frames_sent_r <= frames_sent_r;
            end
            if (frame_wrap_s) begin
              state_r  <= FIN;
              tvalid_r <= 1'b0;
              busy_r   <= 1'b0;
              done_r   <= 1'b1;
            end else if (beat_wrap_s && (gap_r != 8'd0)) begin
              state_r   <= GAP;
              tvalid_r  <= 1'b0;
              gap_cnt_r <= gap_r;
            end else begin
              tdata_r <= tdata_s;
              tkeep_r <= tkeep_s;
              tlast_r <= tlast_s;
              tuser_r <= tuser_s;
            end
          end else begin
            tvalid_r <= 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt_r == 8'd1) begin
            state_r  <= SEND;
            tvalid_r <= 1'b1;
            tdata_r  <= tdata_s;
            tkeep_r  <= tkeep_s;
            tlast_r  <= tlast_s;
            tuser_r  <= tuser_s;
          end else begin
            gap_cnt_r <= gap_cnt_r - 8'd1;
          end
        end
        FIN: begin
          state_r <= IDLE;
        end
        default: begin
          state_r  <= IDLE;
          tvalid_r <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign m_axis_tvalid = tvalid_r;
  assign m_axis_tdata  = tdata_r;
  assign m_axis_tkeep  = tkeep_r;
  assign m_axis_tlast  = tlast_r;
  assign m_axis_tuser  = tuser_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign frames_sent   = frames_sent_r;

endmodule

// File: tb/tb_axis_frame_source.sv
// Directed scoreboard bench for axis_frame_source: expected beats are queued per
// run and popped on each observed transfer.
module tb_axis_frame_source;

  localparam int DATA_W = 32;
  localparam int KEEP_W = 4;
  localparam int USER_W = 1;
  localparam int LEN_W  = 16;

  logic              aclk;
  logic              aresetn;
  logic              start;
  logic [LEN_W-1:0]  frame_len;
  logic [LEN_W-1:0]  num_frames;
  logic [7:0]        gap_cycles;
  logic [KEEP_W-1:0] last_keep;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic [KEEP_W-1:0] m_axis_tkeep;
  logic              m_axis_tlast;
  logic [USER_W-1:0] m_axis_tuser;
  logic              busy;
  logic              done;
  logic [31:0]       frames_sent;

  axis_frame_source #(
    .DATA_W (DATA_W),
    .KEEP_W (KEEP_W),
    .USER_W (USER_W),
    .LEN_W  (LEN_W)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .start         (start),
    .frame_len     (frame_len),
    .num_frames    (num_frames),
    .gap_cycles    (gap_cycles),
    .last_keep     (last_keep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .busy          (busy),
    .done          (done),
    .frames_sent   (frames_sent)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        sof;
  } beat_t;

  beat_t exp_q[$];
  int    n_assert = 0;
  int    n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_run(input int len, input int nf, input logic [3:0] lk);
    int          l;
    logic [3:0]  k;
    beat_t       e;
    logic [31:0] fv;
    logic [31:0] bv;
    l = (len == 0) ? 1 : len;
    k = (lk == 4'h0) ? 4'hF : lk;
    for (int f = 0; f < nf; f++) begin
      for (int b = 0; b < l; b++) begin
        fv     = f;
        bv     = b;
        e.data = {fv[15:0], bv[15:0]};
        e.last = (b == l - 1);
        e.keep = e.last ? k : 4'hF;
        e.sof  = (b == 0);
        exp_q.push_back(e);
      end
    end
  endtask

  // Called at a negedge; returns at the negedge right after the start edge.
  task automatic start_run(input int len, input int nf, input int gap, input logic [3:0] lk);
    frame_len  = 16'(len);
    num_frames = 16'(nf);
    gap_cycles = 8'(gap);
    last_keep  = lk;
    start      = 1'b1;
    @(negedge aclk);
    start      = 1'b0;
    frame_len  = 16'd9;
    num_frames = 16'd5;
    gap_cycles = 8'd7;
    last_keep  = 4'h1;
  endtask

  task automatic run_frames(input int ready_mode, input int exp_gap, input bit pulse_start,
                            output int first_valid, output int n_xfer,
                            output int done_cyc, output int last_xfer_cyc);
    beat_t       e;
    logic [38:0] prev_out;
    bit          prev_stall;
    bit          seen_last;
    bit          fin;
    int          idle_run;
    prev_stall = 1'b0;
    seen_last  = 1'b0;
    fin        = 1'b0;
    idle_run   = 0;
    prev_out   = '0;
    first_valid = -1;
    n_xfer      = 0;
    done_cyc    = -1;
    last_xfer_cyc = -1;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (prev_stall)
        check("stall_hold", 64'({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}),
              64'(prev_out));
      if (m_axis_tvalid && first_valid < 0) first_valid = cyc;
      if (done) begin
        done_cyc = cyc;
        fin      = 1'b1;
      end else begin
        start         = pulse_start && (cyc == 2 || cyc == 5);
        m_axis_tready = (ready_mode == 0) ? 1'b1 : ((cyc % 2) == 1);
        prev_stall    = m_axis_tvalid && !m_axis_tready;
        prev_out      = {1'b1, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
        if (m_axis_tvalid && m_axis_tready) begin
          check("beat_expected", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("beat", 64'({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser[0]}),
                  64'({e.data, e.keep, e.last, e.sof}));
          end
          if (m_axis_tuser[0] && seen_last) check("gap_len", 64'(idle_run), 64'(exp_gap));
          seen_last     = m_axis_tlast;
          idle_run      = 0;
          n_xfer++;
          last_xfer_cyc = cyc;
        end else if (!m_axis_tvalid && seen_last) begin
          idle_run++;
        end
        @(negedge aclk);
      end
    end
    start = 1'b0;
    check("done_seen", 64'(done_cyc >= 0), 64'd1);
  endtask

  task automatic finish_run(input int n_beats, input int n_xfer, input int done_cyc,
                            input int last_xfer_cyc, input int exp_frames);
    check("xfer_count", 64'(n_xfer), 64'(n_beats));
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("done_timing", 64'(done_cyc), 64'(last_xfer_cyc + 1));
    check("fin_busy_low", 64'(busy), 64'd0);
    check("frames_sent", 64'(frames_sent), 64'(exp_frames));
    @(negedge aclk);
    check("done_single", 64'({done, m_axis_tvalid}), 64'd0);
  endtask

  initial begin
    int fv, nx, dc, lx;
    aresetn       = 1'b0;
    start         = 1'b0;
    frame_len     = '0;
    num_frames    = '0;
    gap_cycles    = '0;
    last_keep     = '0;
    m_axis_tready = 1'b0;
    repeat (3) @(negedge aclk);
    check("reset_out", 64'({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, busy, done}),
          64'd0);
    check("reset_frames", 64'(frames_sent), 64'd0);
    aresetn = 1'b1;
    @(negedge aclk);

    // Basic back-to-back frames
    push_run(4, 2, 4'hF);
    start_run(4, 2, 0, 4'hF);
    check("busy_after_start", 64'(busy), 64'd1);
    run_frames(0, 0, 1'b0, fv, nx, dc, lx);
    check("first_valid_latency", 64'(fv), 64'd1);
    finish_run(8, nx, dc, lx, 2);

    // Backpressure with 1/2 duty tready
    push_run(5, 3, 4'hF);
    start_run(5, 3, 0, 4'hF);
    run_frames(1, 0, 1'b0, fv, nx, dc, lx);
    finish_run(15, nx, dc, lx, 5);

    // frame_len=0 gives single-beat frames; tail keep 0x3
    push_run(0, 2, 4'h3);
    start_run(0, 2, 0, 4'h3);
    run_frames(0, 0, 1'b0, fv, nx, dc, lx);
    finish_run(2, nx, dc, lx, 7);

    // last_keep=0 forces all-ones tail
    push_run(3, 1, 4'h0);
    start_run(3, 1, 0, 4'h0);
    run_frames(0, 0, 1'b0, fv, nx, dc, lx);
    finish_run(3, nx, dc, lx, 8);

    // num_frames=0: no beats, done straight away
    start_run(4, 0, 0, 4'hF);
    check("nf0_busy", 64'(busy), 64'd0);
    run_frames(0, 0, 1'b0, fv, nx, dc, lx);
    check("nf0_no_valid", 64'(fv), 64'hFFFF_FFFF_FFFF_FFFF);
    finish_run(0, nx, dc, lx, 8);

    // Inter-frame gap of 3 cycles
    push_run(2, 2, 4'hF);
    start_run(2, 2, 3, 4'hF);
    run_frames(0, 3, 1'b0, fv, nx, dc, lx);
    finish_run(4, nx, dc, lx, 10);

    // start pulses during SEND and GAP are ignored
    push_run(3, 3, 4'hF);
    start_run(3, 3, 2, 4'hF);
    run_frames(0, 2, 1'b1, fv, nx, dc, lx);
    finish_run(9, nx, dc, lx, 13);
    check("no_second_done", 64'({done, busy, m_axis_tvalid}), 64'd0);

    // Reset during beat 2 of a 4-beat frame
    m_axis_tready = 1'b1;
    start_run(4, 1, 0, 4'hF);
    repeat (3) @(negedge aclk);
    check("pre_reset_beat", 64'({m_axis_tvalid, m_axis_tdata}), 64'({1'b1, 32'h0000_0002}));
    aresetn = 1'b0;
    @(negedge aclk);
    check("mid_reset_out", 64'({m_axis_tvalid, m_axis_tlast, busy, done}), 64'd0);
    check("mid_reset_frames", 64'(frames_sent), 64'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    push_run(2, 1, 4'hF);
    start_run(2, 1, 0, 4'hF);
    run_frames(0, 0, 1'b0, fv, nx, dc, lx);
    check("restart_latency", 64'(fv), 64'd1);
    finish_run(2, nx, dc, lx, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
